// File: rtl/lsu_mem_responder_pkg.sv
// lsu_mem_responder_pkg
//   Shared constants and types for the LSU memory responder slice.
//   FE_ADDR_W / FE_DATA_W : front-end address and data widths, common to
//                           every block that talks to the load/store unit.
//   state_e               : responder FSM states.
//   kind_e                : request type of the granted access.
package lsu_mem_responder_pkg;

    localparam int unsigned FE_ADDR_W = 32;
    localparam int unsigned FE_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        KIND_LOAD  = 1'b0,
        KIND_STORE = 1'b1
    } kind_e;

endpackage

// File: rtl/lsu_mem_responder_sp_ram.sv
// lsu_sp_ram
//   Single-port RAM, 2**ADDR_W words of DATA_W bits. Synchronous write,
//   registered read. Contents and the read register are never reset.
//   clk_i   : clock
//   we_i    : write enable (writes wdata_i to addr_i on the rising edge)
//   re_i    : read enable (captures mem[addr_i] into rdata_o on the edge)
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : registered read data, held until the next read
module lsu_sp_ram
    import lsu_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = FE_DATA_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder
//   Serves level-held load and store requests against a local RAM, one at a
//   time, with a fixed LATENCY (edges from grant to completion pulse).
//   Simultaneous requests are granted round-robin between load and store.
//   clk, reset                : clock, synchronous active-high reset
//   load_req/load_addr        : load request (held until load_complete)
//   load_data/load_complete   : read word and one-cycle completion pulse
//   store_req/store_addr/data : store request (held until store_complete)
//   store_complete            : one-cycle completion pulse
//   oob_err                   : sticky, address had bits >= MEM_ADDR_W
//   load_cnt/store_cnt        : wrapping completion counters
module lsu_mem_responder
    import lsu_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_req,
    input  logic [FE_ADDR_W-1:0] load_addr,
    output logic [FE_DATA_W-1:0] load_data,
    output logic                 load_complete,
    input  logic                 store_req,
    input  logic [FE_ADDR_W-1:0] store_addr,
    input  logic [FE_DATA_W-1:0] store_data,
    output logic                 store_complete,
    output logic                 oob_err,
    output logic [31:0]          load_cnt,
    output logic [31:0]          store_cnt
);

    if (LATENCY == 0) begin : g_bad_latency
        $error("lsu_mem_responder: LATENCY must be at least 1");
    end
    if (MEM_ADDR_W == 0 || MEM_ADDR_W > FE_ADDR_W) begin : g_bad_addr_w
        $error("lsu_mem_responder: MEM_ADDR_W must be in 1..FE_ADDR_W");
    end

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e                 state_q, state_d;
    kind_e                  kind_q, kind_d;
    kind_e                  last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FE_ADDR_W-1:0]   addr_q, addr_d;
    logic [FE_DATA_W-1:0]   wdata_q, wdata_d;
    logic [FE_DATA_W-1:0]   load_data_q, load_data_d;
    logic                   oob_q, oob_d;
    logic [31:0]            load_cnt_q, load_cnt_d;
    logic [31:0]            store_cnt_q, store_cnt_d;

    logic                   grant_load;
    logic                   ram_we;
    logic                   ram_re;
    logic [FE_DATA_W-1:0]   ram_rdata;

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        load_data_d    = load_data_q;
        oob_d          = oob_q;
        load_cnt_d     = load_cnt_q;
        store_cnt_d    = store_cnt_q;
        grant_load     = 1'b0;
        ram_we         = 1'b0;
        ram_re         = 1'b0;
        load_complete  = 1'b0;
        store_complete = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (load_req || store_req) begin
                    // Load wins unless only a store is pending, or a tie
                    // follows a load grant.
                    grant_load = load_req && (!store_req || last_q == KIND_STORE);
                    kind_d     = grant_load ? KIND_LOAD : KIND_STORE;
                    last_d     = grant_load ? KIND_LOAD : KIND_STORE;
                    addr_d     = grant_load ? load_addr : store_addr;
                    wdata_d    = store_data;
                    cnt_d      = CNT_INIT;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    ram_we  = (kind_q == KIND_STORE);
                    ram_re  = (kind_q == KIND_LOAD);
                    oob_d   = oob_q | ((addr_q >> MEM_ADDR_W) != '0);
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (kind_q == KIND_LOAD) begin
                    load_complete = 1'b1;
                    load_data_d   = ram_rdata;
                    load_cnt_d    = load_cnt_q + 32'd1;
                end else begin
                    store_complete = 1'b1;
                    store_cnt_d    = store_cnt_q + 32'd1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            kind_q      <= KIND_LOAD;
            last_q      <= KIND_STORE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            oob_q       <= 1'b0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            oob_q       <= oob_d;
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    // Reset gates the write so an access aborted in WAIT leaves RAM intact.
    lsu_sp_ram #(
        .ADDR_W (MEM_ADDR_W),
        .DATA_W (FE_DATA_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we && !reset),
        .re_i    (ram_re && !reset),
        .addr_i  (addr_q[MEM_ADDR_W-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // The RAM read register only becomes valid in RESP, so the fresh word is
    // forwarded during the pulse and the held copy is shown otherwise.
    assign load_data = (state_q == ST_RESP && kind_q == KIND_LOAD) ? ram_rdata : load_data_q;
    assign oob_err   = oob_q;
    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
module tb_lsu_mem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_req = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data;
    logic        load_complete;
    logic        store_req = 1'b0;
    logic [31:0] store_addr = '0;
    logic [31:0] store_data = '0;
    logic        store_complete;
    logic        oob_err;
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_q[$];
    bit          exp_kind_q[$];   // 1 = load, 0 = store

    always #5 clk = ~clk;

    lsu_mem_responder #(
        .MEM_ADDR_W (10),
        .LATENCY    (LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_req       (load_req),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_complete  (load_complete),
        .store_req      (store_req),
        .store_addr     (store_addr),
        .store_data     (store_data),
        .store_complete (store_complete),
        .oob_err        (oob_err),
        .load_cnt       (load_cnt),
        .store_cnt      (store_cnt)
    );

    task automatic do_reset();
        load_req  = 1'b0;
        store_req = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drives one request from an idle DUT and holds it until its completion.
    // lat = edges from the grant edge to the visible pulse; stuck = pulse
    // still high one cycle later.
    task automatic issue(input bit is_load, input logic [31:0] addr, input logic [31:0] data,
                         output int lat, output bit got, output logic [31:0] rdata, output bit stuck);
        got   = 1'b0;
        rdata = '0;
        lat   = -1;
        if (is_load) begin
            load_addr = addr;
            load_req  = 1'b1;
        end else begin
            store_addr = addr;
            store_data = data;
            store_req  = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (is_load ? load_complete : store_complete) begin
                got   = 1'b1;
                rdata = load_data;
            end
        end
        load_req  = 1'b0;
        store_req = 1'b0;
        // Scramble inputs after the request drops; they must not matter.
        load_addr  = 32'hFFFF_FFFF;
        store_data = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        stuck = load_complete | store_complete;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (load_complete !== 1'b0) begin bad++; $display("FAIL reset_load_complete got=%b want=0", load_complete); end
        total++; if (store_complete !== 1'b0) begin bad++; $display("FAIL reset_store_complete got=%b want=0", store_complete); end
        total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL reset_oob got=%b want=0", oob_err); end
        total++; if (load_data !== 32'h0) begin bad++; $display("FAIL reset_load_data got=%h want=0", load_data); end
        total++; if (load_cnt !== 32'h0) begin bad++; $display("FAIL reset_load_cnt got=%0d want=0", load_cnt); end
        total++; if (store_cnt !== 32'h0) begin bad++; $display("FAIL reset_store_cnt got=%0d want=0", store_cnt); end
    endtask

    task automatic test_store_load();
        int lat; bit got; bit stuck; logic [31:0] rd; logic [31:0] exp;
        issue(1'b0, 32'd5, 32'hDEAD_BEEF, lat, got, rd, stuck);
        total++; if (!got) begin bad++; $display("FAIL st_pulse got=none want=pulse"); end
        total++; if (lat != int'(LAT)) begin bad++; $display("FAIL st_latency got=%0d want=%0d", lat, LAT); end
        total++; if (stuck) begin bad++; $display("FAIL st_one_cycle got=2+ want=1"); end
        total++; if (store_cnt !== 32'd1) begin bad++; $display("FAIL st_cnt got=%0d want=1", store_cnt); end
        total++; if (load_cnt !== 32'd0) begin bad++; $display("FAIL st_ld_cnt got=%0d want=0", load_cnt); end

        exp_q.push_back(32'hDEAD_BEEF);
        issue(1'b1, 32'd5, 32'h0, lat, got, rd, stuck);
        exp = exp_q.pop_front();
        total++; if (!got) begin bad++; $display("FAIL ld_pulse got=none want=pulse"); end
        total++; if (rd !== exp) begin bad++; $display("FAIL ld_data got=%h want=%h", rd, exp); end
        total++; if (lat != int'(LAT)) begin bad++; $display("FAIL ld_latency got=%0d want=%0d", lat, LAT); end
        total++; if (load_cnt !== 32'd1) begin bad++; $display("FAIL ld_cnt got=%0d want=1", load_cnt); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (load_data !== exp) begin bad++; $display("FAIL ld_hold got=%h want=%h", load_data, exp); end
    endtask

    task automatic test_round_robin();
        int lat; bit got; bit stuck; logic [31:0] rd;
        int seen;
        bit ek;
        logic [31:0] exp;
        issue(1'b0, 32'd3, 32'h0, lat, got, rd, stuck);
        do_reset();
        exp_kind_q = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h11);
        load_addr  = 32'd3;
        store_addr = 32'd3;
        store_data = 32'h11;
        load_req   = 1'b1;
        store_req  = 1'b1;
        seen = 0;
        for (int i = 0; i < 60 && seen < 4; i++) begin
            @(posedge clk);
            #1;
            if (load_complete && store_complete) begin
                total++; bad++;
                $display("FAIL rr_both_pulses got=both want=one");
            end else if (load_complete || store_complete) begin
                ek = exp_kind_q.pop_front();
                seen++;
                total++;
                if (load_complete !== ek) begin
                    bad++;
                    $display("FAIL rr_order_%0d got_load=%b want_load=%b", seen, load_complete, ek);
                end
                if (load_complete) begin
                    exp = exp_q.pop_front();
                    total++;
                    if (load_data !== exp) begin
                        bad++;
                        $display("FAIL rr_ld_data_%0d got=%h want=%h", seen, load_data, exp);
                    end
                end
            end
        end
        load_req  = 1'b0;
        store_req = 1'b0;
        total++; if (seen != 4) begin bad++; $display("FAIL rr_count got=%0d want=4", seen); end
        exp_q.delete();
        exp_kind_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_oob();
        int lat; bit got; bit stuck; logic [31:0] rd; logic [31:0] exp;
        do_reset();
        issue(1'b0, 32'h400, 32'h55, lat, got, rd, stuck);
        total++; if (!got) begin bad++; $display("FAIL oob_st_pulse got=none want=pulse"); end
        total++; if (oob_err !== 1'b1) begin bad++; $display("FAIL oob_set got=%b want=1", oob_err); end
        exp_q.push_back(32'h55);
        issue(1'b1, 32'h0, 32'h0, lat, got, rd, stuck);
        exp = exp_q.pop_front();
        total++; if (rd !== exp) begin bad++; $display("FAIL oob_wrap_data got=%h want=%h", rd, exp); end
        repeat (4) @(posedge clk);
        #1;
        total++; if (oob_err !== 1'b1) begin bad++; $display("FAIL oob_sticky got=%b want=1", oob_err); end
        do_reset();
        total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL oob_clear got=%b want=0", oob_err); end
    endtask

    task automatic test_reset_abort();
        int lat; bit got; bit stuck; logic [31:0] rd; logic [31:0] exp;
        int pulses;
        issue(1'b0, 32'd7, 32'h22, lat, got, rd, stuck);
        store_addr = 32'd7;
        store_data = 32'h33;
        store_req  = 1'b1;
        @(posedge clk);   // grant edge
        #1;
        store_req = 1'b0;
        reset     = 1'b1;
        pulses    = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (store_complete) pulses++;
        end
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (store_complete) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL abort_pulse got=%0d want=0", pulses); end
        total++; if (store_cnt !== 32'd0) begin bad++; $display("FAIL abort_st_cnt got=%0d want=0", store_cnt); end
        total++; if (load_cnt !== 32'd0) begin bad++; $display("FAIL abort_ld_cnt got=%0d want=0", load_cnt); end
        exp_q.push_back(32'h22);
        issue(1'b1, 32'd7, 32'h0, lat, got, rd, stuck);
        exp = exp_q.pop_front();
        total++; if (rd !== exp) begin bad++; $display("FAIL abort_mem got=%h want=%h", rd, exp); end
    endtask

    task automatic test_back_to_back();
        int lat; bit got; bit stuck; logic [31:0] rd; logic [31:0] exp;
        int pulses;
        for (int unsigned a = 0; a < 4; a++) begin
            issue(1'b0, 32'h10 + a, 32'hC0DE_0000 + a * 32'h111, lat, got, rd, stuck);
        end
        do_reset();
        pulses = 0;
        for (int unsigned a = 0; a < 4; a++) begin
            exp_q.push_back(32'hC0DE_0000 + a * 32'h111);
            issue(1'b1, 32'h10 + a, 32'h0, lat, got, rd, stuck);
            if (got) pulses++;
            exp = exp_q.pop_front();
            total++;
            if (rd !== exp) begin
                bad++;
                $display("FAIL b2b_data_%0d got=%h want=%h", a, rd, exp);
            end
        end
        total++; if (pulses != 4) begin bad++; $display("FAIL b2b_pulses got=%0d want=4", pulses); end
        total++; if (load_cnt !== 32'd4) begin bad++; $display("FAIL b2b_ld_cnt got=%0d want=4", load_cnt); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_round_robin();
        test_oob();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
